// File: rtl/muldiv_unit_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Holds the op encodings, HI/LO access encodings and the unit's FSM state type.
package mips_md_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [2:0] {
    NONE = 3'b000,
    MFHI = 3'b001,
    MFLO = 3'b010,
    MTHI = 3'b011,
    MTLO = 3'b100
  } hilo_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Unused encodings 101..111 collapse to NONE so they never stall or write.
  function automatic hilo_op_t decode_hilo(input logic [2:0] raw);
    hilo_op_t res;
    case (raw)
      3'b001:  res = MFHI;
      3'b010:  res = MFLO;
      3'b011:  res = MTHI;
      3'b100:  res = MTLO;
      default: res = NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// Handshake: MdStartE is a one-cycle request that is accepted only while MdBusy=0; while MdStallE=1 the pipeline holds E unchanged.
interface muldiv_unit_if #(
  parameter int WIDTH = mips_md_pkg::MD_WIDTH
);

  logic                   MdStartE;
  logic [1:0]             MdOpE;
  logic [2:0]             HiLoOpE;
  logic [WIDTH-1:0]       SrcAE;
  logic [WIDTH-1:0]       SrcBE;
  logic [WIDTH-1:0]       HiLoOutE;
  logic                   MdStallE;
  logic                   MdBusy;
  mips_md_pkg::md_state_t MdState;

  modport master (
    output MdStartE, MdOpE, HiLoOpE, SrcAE, SrcBE,
    input  HiLoOutE, MdStallE, MdBusy, MdState
  );

  modport slave (
    input  MdStartE, MdOpE, HiLoOpE, SrcAE, SrcBE,
    output HiLoOutE, MdStallE, MdBusy, MdState
  );

endinterface

// File: rtl/muldiv_unit_iter_core.sv
// Per-cycle unsigned datapath: shift-add multiply or restoring divide, one bit per cycle.
// Operates on magnitudes only; sign handling lives in the parent.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             busy_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // acc holds product-high / partial remainder; shf holds multiplier-then-product-low / dividend-then-quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  always_comb begin
    mul_sum   = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {acc_q, shf_q[WIDTH-1]};
    // A set top bit already exceeds any W-bit divisor; the W-bit difference is exact whenever div_ok.
    div_ok    = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= opb_q);
    div_rem   = div_shift[WIDTH-1:0] - opb_q;
    if (is_div_i) begin
      step_hi = div_ok ? div_rem : div_shift[WIDTH-1:0];
      step_lo = {shf_q[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], shf_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d = acc_q;
    shf_d = shf_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
    if (start_i) begin
      acc_d = '0;
      shf_d = a_i;
      opb_d = b_i;
      cnt_d = '0;
    end else if (busy_i) begin
      acc_d = step_hi;
      shf_d = step_lo;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      acc_q <= '0;
      shf_q <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      shf_q <= shf_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o   = busy_i & (cnt_q == CNT_LAST);
  assign res_hi_o = step_hi;
  assign res_lo_o = step_lo;

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit owning HI/LO: FSM, sign fixup, HI/LO access and stall request.
// Results land in HI/LO on the same edge as the last datapath iteration.
module muldiv_unit
  import mips_md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);

  md_state_t        state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             is_div_q, is_div_d;

  hilo_op_t         hilo_op;
  md_op_t           op;
  logic             op_signed;
  logic             op_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_acc;
  logic             busy;
  logic             core_done;
  logic [WIDTH-1:0] raw_hi;
  logic [WIDTH-1:0] raw_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  assign hilo_op   = decode_hilo(bus.HiLoOpE);
  assign op        = md_op_t'(bus.MdOpE);
  assign op_signed = (op == MULT) | (op == DIV);
  assign op_div    = (op == DIV) | (op == DIVU);
  assign a_neg     = op_signed & bus.SrcAE[WIDTH-1];
  assign b_neg     = op_signed & bus.SrcBE[WIDTH-1];
  // Unsigned magnitude keeps the most-negative operand representable without overflow.
  assign a_mag     = a_neg ? -bus.SrcAE : bus.SrcAE;
  assign b_mag     = b_neg ? -bus.SrcBE : bus.SrcBE;
  assign start_acc = (state_q == IDLE) & bus.MdStartE;

  md_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .start_i   (start_acc),
    .busy_i    (busy),
    .is_div_i  (is_div_q),
    .a_i       (a_mag),
    .b_i       (b_mag),
    .done_o    (core_done),
    .res_hi_o  (raw_hi),
    .res_lo_o  (raw_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.MdStartE) state_d = BUSY;
      BUSY:    if (core_done)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state_q == BUSY) busy = 1'b1;
  end

  assign bus.MdBusy   = busy;
  assign bus.MdStallE = busy & (bus.MdStartE | (hilo_op != NONE));
  assign bus.MdState  = state_q;

  always_comb begin
    bus.HiLoOutE = '0;
    case (hilo_op)
      MFHI:    bus.HiLoOutE = hi_q;
      MFLO:    bus.HiLoOutE = lo_q;
      default: bus.HiLoOutE = '0;
    endcase
  end

  assign prod     = {raw_hi, raw_lo};
  assign prod_fix = neg_res_q ? -prod : prod;

  // A start in IDLE takes priority over a simultaneous MTHI/MTLO, which is dropped.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    if (start_acc) begin
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      is_div_d  = op_div;
    end else if (core_done) begin
      if (is_div_q) begin
        lo_d = neg_res_q ? -raw_lo : raw_lo;
        hi_d = neg_rem_q ? -raw_hi : raw_hi;
      end else begin
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
      end
    end else if (state_q == IDLE) begin
      if (hilo_op == MTHI) hi_d = bus.SrcAE;
      if (hilo_op == MTLO) lo_d = bus.SrcAE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic HI/LO reference model.
module tb_muldiv_unit;
  import mips_md_pkg::*;

  localparam int W = MD_WIDTH;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  muldiv_unit_if #(.WIDTH(W)) ifc();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // HI/LO as the instruction set defines them, using native arithmetic.
  function automatic void ref_md(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      default: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
    endcase
  endfunction

  task automatic idle_inputs();
    ifc.MdStartE = 1'b0;
    ifc.MdOpE    = 2'b00;
    ifc.HiLoOpE  = 3'b000;
    ifc.SrcAE    = '0;
    ifc.SrcBE    = '0;
  endtask

  task automatic read_hilo(input logic [2:0] sel, input string tag, input logic [W-1:0] exp);
    @(posedge clk); #1;
    ifc.HiLoOpE = sel;
    ifc.MdStartE = 1'b0;
    @(negedge clk);
    chk(tag, ifc.HiLoOutE, exp);
  endtask

  // Issue one op, run `idle` unrelated cycles, then hold MFLO in E until the stall drops.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int idle, input logic [2:0] side_hilo, input string tag);
    logic [W-1:0] rh, rl;
    int busy_n, stall_n;
    bit done;
    ref_md(op, a, b, rh, rl);
    exp_q.push_back(rl);
    exp_q.push_back(rh);
    @(posedge clk); #1;
    ifc.MdStartE = 1'b1;
    ifc.MdOpE    = op;
    ifc.SrcAE    = a;
    ifc.SrcBE    = b;
    ifc.HiLoOpE  = side_hilo;
    @(posedge clk); #1;
    ifc.MdStartE = 1'b0;
    ifc.SrcAE    = $urandom;
    ifc.SrcBE    = $urandom;
    ifc.HiLoOpE  = (idle > 0) ? 3'b000 : 3'b010;
    busy_n = 0;
    stall_n = 0;
    done = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      if (ifc.MdBusy) busy_n++;
      if (cyc <= idle) begin
        chk({tag, "_nostall"}, W'(ifc.MdStallE), '0);
        @(posedge clk); #1;
        ifc.SrcAE = $urandom;
        if (cyc == idle) ifc.HiLoOpE = 3'b010;
      end else if (ifc.MdStallE) begin
        stall_n++;
        @(posedge clk); #1;
      end else begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_busy_cycles"}, W'(busy_n), W'(W));
    chk({tag, "_stall_cycles"}, W'(stall_n), W'(W - idle));
    chk({tag, "_lo"}, ifc.HiLoOutE, exp_q.pop_front());
    read_hilo(3'b001, {tag, "_hi"}, exp_q.pop_front());
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ifc.HiLoOpE = 3'b001;
    @(negedge clk);
    chk("rst_mfhi", ifc.HiLoOutE, '0);
    chk("rst_busy", W'(ifc.MdBusy), '0);
    chk("rst_stall", W'(ifc.MdStallE), '0);
    read_hilo(3'b010, "rst_mflo", '0);

    do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 3'b000, "multu_max");
    do_op(MULT, 32'hFFFF_FFF9, 32'd3, 0, 3'b000, "mult_m7x3");
    do_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, 3'b000, "div_m7d2");
    do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'b000, "div_minneg");
    do_op(DIVU, 32'd100, 32'd0, 4, 3'b000, "divu_zero_add");
    do_op(MULT, 32'h8000_0000, 32'h8000_0000, 2, 3'b000, "mult_minneg");
    do_op(DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 1, 3'b000, "divu_big");
    do_op(MULTU, 32'd5, 32'd6, 0, 3'b011, "start_wins_mthi");

    @(posedge clk); #1;
    ifc.HiLoOpE = 3'b011;
    ifc.SrcAE   = 32'h0000_1234;
    read_hilo(3'b001, "mthi", 32'h0000_1234);
    @(posedge clk); #1;
    ifc.HiLoOpE = 3'b100;
    ifc.SrcAE   = 32'hCAFE_F00D;
    read_hilo(3'b010, "mtlo", 32'hCAFE_F00D);
    read_hilo(3'b001, "mtlo_keeps_hi", 32'h0000_1234);
    read_hilo(3'b111, "bad_hilo_zero", '0);

    repeat (12) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 3) == 0) rb = W'($urandom_range(1, 9));
      if (rop == 2'b10 && rb == '0) ra[W-1] = 1'b0;
      do_op(rop, ra, rb, $urandom_range(0, 5), 3'b000, "rand");
    end

    @(posedge clk); #1;
    ifc.MdStartE = 1'b1;
    ifc.MdOpE    = DIVU;
    ifc.SrcAE    = 32'd1000;
    ifc.SrcBE    = 32'd7;
    @(posedge clk); #1;
    idle_inputs();
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    ifc.HiLoOpE = 3'b010;
    @(negedge clk);
    chk("abort_busy", W'(ifc.MdBusy), '0);
    chk("abort_lo", ifc.HiLoOutE, '0);
    read_hilo(3'b001, "abort_hi", '0);
    @(posedge clk); #1;
    idle_inputs();
    do_op(DIV, 32'd1000, 32'hFFFF_FFF9, 0, 3'b000, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
